// File: rtl/alu_pkg.sv
// Shared definitions for the RV64 ALU: operation codes (also used by the ALU
// control decoder), sequencer state encoding and the default datapath width.
package alu_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    logic r;
    r = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_logic.sv
// Single-cycle ALU operations. Shift codes pass operand A through unchanged;
// the iterative shifter in alu_seq does the actual shifting.
module alu_seq_logic
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res,
  output logic            err
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic                   lt_s;
  logic                   lt_u;

  assign a_s  = a;
  assign b_s  = b;
  assign lt_s = (a_s < b_s);
  assign lt_u = (a < b);

  always_comb begin
    res = '0;
    err = 1'b0;
    case (op)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  res = a + b;
      ALU_XOR:  res = a ^ b;
      ALU_SUB:  res = a - b;
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, lt_u};
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLL, ALU_SRL, ALU_SRA: res = a;
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle RV64 execution unit: single-cycle logic ops complete immediately,
// shifts iterate one bit per cycle. Valid/ready handshake on issue and result.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            err
);

  localparam int SW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [3:0]      op_q, op_d;

  logic [XLEN-1:0] logic_res;
  logic            logic_err;
  logic [SW-1:0]   shamt;

  assign shamt = b[SW-1:0];

  alu_seq_logic #(.XLEN(XLEN)) u_logic (
    .op  (alu_op),
    .a   (a),
    .b   (b),
    .res (logic_res),
    .err (logic_err)
  );

  function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    case (op)
      ALU_SLL: r = {v[XLEN-2:0], 1'b0};
      ALU_SRA: r = {v[XLEN-1], v[XLEN-1:1]};
      default: r = {1'b0, v[XLEN-1:1]};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    acc_d    = acc_q;
    op_d     = op_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = alu_op;
          if (is_shift_op(alu_op)) begin
            acc_d = a;
            cnt_d = shamt;
            if (shamt == '0) begin
              result_d = a;
              err_d    = 1'b0;
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_SHIFT;
            end
          end else begin
            result_d = logic_res;
            err_d    = logic_err;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = shift_one(op_q, acc_q);
        cnt_d = cnt_q - SW'(1);
        // The last shift lands straight in the result register.
        if (cnt_q == SW'(1)) begin
          result_d = acc_d;
          err_d    = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Shift working registers are only meaningful after an accept.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    op_q  <= op_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign err       = err_q;
  assign zero      = ~|result_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle RV64 execution unit that consumes the 4-bit ALU operation code produced by the ALU control decoder and returns a result. It sits in the EX stage of the multi-cycle datapath: issue logic presents operands plus the code, and the write-back/branch logic collects the result. Single-cycle ops complete in one cycle; shifts iterate one bit per cycle to save area. Valid/ready handshakes are used on both sides.

## Interface
- XLEN, 64, operand/result width (power of two; shift amount width SW = log2(XLEN))
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept (high only in IDLE)
- alu_op  input  4  operation code (encoding below)
- a  input  XLEN  operand A (shift source)
- b  input  XLEN  operand B (shift amount = b[SW-1:0])
- out_valid  output  1  result held and valid
- out_ready  input  1  consumer takes result
- result  output  XLEN  operation result
- zero  output  1  result == 0 (used for beq/bne)
- err  output  1  alu_op was not a defined code

## Operation
- Codes: 0000 and, 0001 or, 0010 add, 0011 xor, 0100 sll, 0101 srl, 0110 sub, 0111 sltu, 1000 slt, 1001 sra; 1010–1111 undefined.
- States IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid: latch op, a, b.
  - Non-shift defined op: compute, register result, go DONE.
  - Shift op: load acc=a, cnt=b[SW-1:0]; cnt==0 -> go DONE with result=a; else go SHIFT.
  - Undefined op: result=0, err=1, go DONE.
- SHIFT: each cycle acc shifts by one bit (sll: left, zero fill; srl: right, zero fill; sra: right, replicate acc[XLEN-1]); cnt decrements; when cnt reaches 1 the final shift is performed and state goes DONE.
- DONE: out_valid=1; result/zero/err stable. When out_ready=1 go IDLE; otherwise hold indefinitely.
- Arithmetic: add/sub modulo 2^XLEN, carry discarded. slt signed compare, sltu unsigned; result is 1 or 0 zero-extended.
- zero is derived from the registered result, so it is valid whenever out_valid=1.
- in_valid while not in IDLE is ignored (in_ready=0); operands are not sampled.

## Timing
- Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, err=0, cnt=0.
- Accept edge = cycle 0. Non-shift, undefined, or shift by 0: out_valid from cycle 1.
- Shift by n (1..XLEN-1): out_valid from cycle n+1.
- Handshake completes on an edge where out_valid && out_ready. in_ready rises the following cycle, so minimum issue interval is 2 cycles.
- Reset asserted mid-SHIFT or in DONE: the operation is discarded and no out_valid is produced after release.
- Result and err change only on entry to DONE; they hold their value in IDLE until the next DONE.

## Structure
- Shared package (alu_pkg): the 4-bit ALU operation code constants (also used by the ALU control decoder), the state encoding, and XLEN default.
- One sub-module is natural: alu_seq_logic, combinational, computing and/or/add/xor/sub/slt/sltu/err from op, a and b. The FSM, shift accumulator and counter stay in alu_seq.

## Test plan
- Reset mid-SHIFT (sll, b=40, reset at cycle 10) -> outputs at reset values immediately; no out_valid after release; next accept works normally.
- add a=0xFFFFFFFFFFFFFFFF, b=1 -> result=0, zero=1, out_valid at cycle 1; sub a=5, b=7 -> 0xFFFFFFFFFFFFFFFE, zero=0.
- slt a=-1, b=1 -> 1; sltu with the same operands -> 0; undefined op 1111 -> result=0, err=1, out_valid at cycle 1.
- sra a=0x8000000000000000, b=63 -> 0xFFFFFFFFFFFFFFFF with out_valid first at cycle 64; srl with the same operands -> 1; sll a=1, b=0 -> 1 at cycle 1.
- Backpressure: xor result held with out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout; in_valid pulses in that window ignored; after out_ready=1, in_ready=1 the next cycle.
- Back-to-back: in_valid held high with and, or, add each time in_ready=1, out_ready=1 -> one result every 2 cycles, in issue order.
